conv_job_scheduler: RTL and testbench

Round-robin scheduler that shares one 3x3/7x7 pipelined convolution engine between two requesters. It grants a job and forwards the winner's 49-beat IFM stream, with the 9 weights overlaid on the first 9 beats, into the engine. It collects the 25 OFM results and returns them tagged with the requester ID. It also detects aborted streams and stalled engines, then flushes the engine before the next job.

---
 rtl/conv_job_scheduler.sv | 262 ++++++++++++++++++++++++++
 tb/tb_conv_job_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_job_scheduler.sv
// conv_job_scheduler
//   Round-robin scheduler sharing one pipelined convolution engine between two
//   requesters. The winner's IFM stream is forwarded to the engine, with its
//   weights overlaid on the first W_LEN beats. OFM results are returned tagged
//   with the owner. Aborted streams and stalled engines end the job with an
//   error pulse. Every job, good or bad, is followed by an engine flush.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req[1:0]                level job request per requester
//   gnt[1:0]                one-hot one-cycle grant pulse
//   s_valid[1:0]            per-requester beat valid
//   s0_ifm/s0_w, s1_ifm/s1_w  requester IFM and weight beats
//   eng_in_valid, eng_weight_valid, eng_ifm, eng_weight   engine input side
//   eng_out_valid, eng_ofm  engine result side
//   ofm_valid, ofm_data, ofm_id, ofm_last                  returned results
//   job_done[1:0], job_err[1:0]                            per-requester pulses
//
// Optional build macro CONV_SCHED_STATS_EN adds saturating 16-bit counters
//   stat_ok (completed jobs) and stat_err (failed jobs).
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for a request, arbitration happens here
//   S_LOAD  | grant issued, streaming beats and collecting results, timeout armed
//           | once all beats are loaded
//   S_FLUSH | engine draining, leave after FLUSH_CYC cycles without a result

module conv_job_scheduler #(
    parameter int DATA_W    = 16,
    parameter int OUT_W     = 36,
    parameter int IFM_LEN   = 49,
    parameter int W_LEN     = 9,
    parameter int OFM_LEN   = 25,
    parameter int TIMEOUT   = 16,
    parameter int FLUSH_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    input  logic [1:0]        s_valid,
    input  logic [DATA_W-1:0] s0_ifm,
    input  logic [DATA_W-1:0] s0_w,
    input  logic [DATA_W-1:0] s1_ifm,
    input  logic [DATA_W-1:0] s1_w,
    output logic              eng_in_valid,
    output logic              eng_weight_valid,
    output logic [DATA_W-1:0] eng_ifm,
    output logic [DATA_W-1:0] eng_weight,
    input  logic              eng_out_valid,
    input  logic [OUT_W-1:0]  eng_ofm,
    output logic              ofm_valid,
    output logic [OUT_W-1:0]  ofm_data,
    output logic              ofm_id,
    output logic              ofm_last,
    output logic [1:0]        job_done,
    output logic [1:0]        job_err
`ifdef CONV_SCHED_STATS_EN
    ,
    output logic [15:0]       stat_ok,
    output logic [15:0]       stat_err
`endif
);

    localparam int BW  = $clog2(IFM_LEN + 1);
    localparam int OCW = $clog2(OFM_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int QW  = $clog2(FLUSH_CYC + 1);

    localparam logic [BW-1:0]  L_IFM      = BW'(IFM_LEN);
    localparam logic [BW-1:0]  L_WLEN     = BW'(W_LEN);
    localparam logic [OCW-1:0] L_OFM      = OCW'(OFM_LEN);
    localparam logic [OCW-1:0] L_OFM_LAST = OCW'(OFM_LEN - 1);
    localparam logic [TW-1:0]  L_TMO      = TW'(TIMEOUT - 1);
    localparam logic [QW-1:0]  L_QUIET    = QW'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_sel;
    logic               r_last;      // last-served requester
    logic [BW-1:0]      r_beat;
    logic [OCW-1:0]     r_ocnt;
    logic [TW-1:0]      r_tmo;
    logic [QW-1:0]      r_quiet;

    logic [1:0]         r_gnt;
    logic               r_eng_in_valid;
    logic               r_eng_weight_valid;
    logic [DATA_W-1:0]  r_eng_ifm;
    logic [DATA_W-1:0]  r_eng_weight;
    logic               r_ofm_valid;
    logic [OUT_W-1:0]   r_ofm_data;
    logic               r_ofm_id;
    logic               r_ofm_last;
    logic [1:0]         r_job_done;
    logic [1:0]         r_job_err;

    logic               w_win;
    logic [1:0]         w_sel_oh;
    logic               w_sel_valid;
    logic [DATA_W-1:0]  w_ifm;
    logic [DATA_W-1:0]  w_w;
    logic               w_res;
    logic               w_done;
    logic               w_streaming;
    logic               w_armed;

    // Both requesting: the one not served last wins; otherwise the lone requester.
    assign w_win       = (&req) ? ~r_last : req[1];
    assign w_sel_oh    = r_sel ? 2'b10 : 2'b01;
    assign w_sel_valid = r_sel ? s_valid[1] : s_valid[0];
    assign w_ifm       = r_sel ? s1_ifm : s0_ifm;
    assign w_w         = r_sel ? s1_w : s0_w;
    assign w_res       = (r_state == S_LOAD) && eng_out_valid && (r_ocnt < L_OFM);
    assign w_done      = w_res && (r_ocnt == L_OFM_LAST);
    assign w_streaming = (r_beat < L_IFM);
    // The grant cycle itself carries no beat; streaming starts the cycle after.
    assign w_armed     = (r_gnt == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_sel              <= 1'b0;
            r_last             <= 1'b1;
            r_beat             <= '0;
            r_ocnt             <= '0;
            r_tmo              <= '0;
            r_quiet            <= '0;
            r_gnt              <= 2'b00;
            r_eng_in_valid     <= 1'b0;
            r_eng_weight_valid <= 1'b0;
            r_eng_ifm          <= '0;
            r_eng_weight       <= '0;
            r_ofm_valid        <= 1'b0;
            r_ofm_data         <= '0;
            r_ofm_id           <= 1'b0;
            r_ofm_last         <= 1'b0;
            r_job_done         <= 2'b00;
            r_job_err          <= 2'b00;
        end else begin
            r_gnt              <= 2'b00;
            r_eng_in_valid     <= 1'b0;
            r_eng_weight_valid <= 1'b0;
            r_eng_ifm          <= '0;
            r_eng_weight       <= '0;
            r_ofm_valid        <= 1'b0;
            r_ofm_last         <= 1'b0;
            r_job_done         <= 2'b00;
            r_job_err          <= 2'b00;

            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_gnt   <= w_win ? 2'b10 : 2'b01;
                        r_sel   <= w_win;
                        r_beat  <= '0;
                        r_ocnt  <= '0;
                        r_tmo   <= L_TMO;
                        r_state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (w_res) begin
                        r_ofm_valid <= 1'b1;
                        r_ofm_data  <= eng_ofm;
                        r_ofm_id    <= r_sel;
                        r_ocnt      <= r_ocnt + 1'b1;
                    end

                    if (w_done) begin
                        r_ofm_last <= 1'b1;
                        r_job_done <= w_sel_oh;
                        r_last     <= r_sel;
                        r_quiet    <= L_QUIET;
                        r_state    <= S_FLUSH;
                    end else if (w_streaming) begin
                        if (w_armed) begin
                            if (w_sel_valid) begin
                                r_eng_in_valid     <= 1'b1;
                                r_eng_ifm          <= w_ifm;
                                r_eng_weight_valid <= (r_beat < L_WLEN);
                                r_eng_weight       <= (r_beat < L_WLEN) ? w_w : '0;
                                r_beat             <= r_beat + 1'b1;
                            end else begin
                                r_job_err <= w_sel_oh;
                                r_last    <= r_sel;
                                r_quiet   <= L_QUIET;
                                r_state   <= S_FLUSH;
                            end
                        end
                    end else begin
                        // Stall detection: down-counter reloaded by every result.
                        if (eng_out_valid) begin
                            r_tmo <= L_TMO;
                        end else if (r_tmo == '0) begin
                            r_job_err <= w_sel_oh;
                            r_last    <= r_sel;
                            r_quiet   <= L_QUIET;
                            r_state   <= S_FLUSH;
                        end else begin
                            r_tmo <= r_tmo - 1'b1;
                        end
                    end
                end

                S_FLUSH: begin
                    if (eng_out_valid) begin
                        r_quiet <= L_QUIET;
                    end else if (r_quiet == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_quiet <= r_quiet - 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt              = r_gnt;
    assign eng_in_valid     = r_eng_in_valid;
    assign eng_weight_valid = r_eng_weight_valid;
    assign eng_ifm          = r_eng_ifm;
    assign eng_weight       = r_eng_weight;
    assign ofm_valid        = r_ofm_valid;
    assign ofm_data         = r_ofm_data;
    assign ofm_id           = r_ofm_id;
    assign ofm_last         = r_ofm_last;
    assign job_done         = r_job_done;
    assign job_err          = r_job_err;

`ifdef CONV_SCHED_STATS_EN
    logic [15:0] r_stat_ok;
    logic [15:0] r_stat_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_ok  <= '0;
            r_stat_err <= '0;
        end else begin
            if ((|r_job_done) && (r_stat_ok != 16'hFFFF)) begin
                r_stat_ok <= r_stat_ok + 16'd1;
            end
            if ((|r_job_err) && (r_stat_err != 16'hFFFF)) begin
                r_stat_err <= r_stat_err + 16'd1;
            end
        end
    end

    assign stat_ok  = r_stat_ok;
    assign stat_err = r_stat_err;
`endif

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Testbench for conv_job_scheduler: a table of job vectors driven through one
// job task, with beat and result scoreboards checked every cycle, plus hand
// sequences for flush timing and mid-job reset.
module tb_conv_job_scheduler;
    localparam int DATA_W = 16;
    localparam int OUT_W  = 36;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic [1:0]        s_valid;
    logic [DATA_W-1:0] s0_ifm, s0_w, s1_ifm, s1_w;
    logic              eng_in_valid, eng_weight_valid;
    logic [DATA_W-1:0] eng_ifm, eng_weight;
    logic              eng_out_valid;
    logic [OUT_W-1:0]  eng_ofm;
    logic              ofm_valid;
    logic [OUT_W-1:0]  ofm_data;
    logic              ofm_id, ofm_last;
    logic [1:0]        job_done, job_err;
`ifdef CONV_SCHED_STATS_EN
    logic [15:0]       stat_ok, stat_err;
`endif

    always #5 clk = ~clk;

    conv_job_scheduler dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .s_valid(s_valid),
        .s0_ifm(s0_ifm), .s0_w(s0_w), .s1_ifm(s1_ifm), .s1_w(s1_w),
        .eng_in_valid(eng_in_valid), .eng_weight_valid(eng_weight_valid),
        .eng_ifm(eng_ifm), .eng_weight(eng_weight),
        .eng_out_valid(eng_out_valid), .eng_ofm(eng_ofm),
        .ofm_valid(ofm_valid), .ofm_data(ofm_data), .ofm_id(ofm_id), .ofm_last(ofm_last),
        .job_done(job_done), .job_err(job_err)
`ifdef CONV_SCHED_STATS_EN
        , .stat_ok(stat_ok), .stat_err(stat_err)
`endif
    );

    typedef struct {
        logic [DATA_W-1:0] ifm;
        logic              wv;
        logic [DATA_W-1:0] w;
    } beat_t;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             id;
        logic             last;
    } res_t;

    // One job: request pattern, expected winner, stream length (49 or abort
    // point), engine result schedule, and expected outcome.
    typedef struct {
        logic [1:0] req;
        bit         hold;
        bit         win;
        int         nsend;
        int         nres;
        int         rstart;
        int         fwd;
        bit         done;
        bit         err;
        bit         last;
        int         gap;   // expected ticks from previous job end to grant, 0 = unchecked
    } vec_t;

    beat_t bq[$];
    res_t  rq[$];
    vec_t  vecs[6];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int gnt_cnt = 0;
    int gnt_cyc = 0;
    int end_cyc = 0;
    int last_ofm_cyc = 0;
    int jid = 0;
    logic [1:0] last_gnt = 2'b00;
    logic [1:0] mon_done = 2'b00;
    logic [1:0] mon_err = 2'b00;
    logic       mon_last = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, 64'({gnt, eng_in_valid, eng_weight_valid, ofm_valid,
                                   ofm_id, ofm_last, job_done, job_err}), 64'h0);
        check({tag, "_eng"}, 64'({eng_ifm, eng_weight}), 64'h0);
        check({tag, "_ofm"}, 64'(ofm_data), 64'h0);
    endtask

    // Advance to the next falling edge and check everything the DUT presents.
    task automatic tick();
        beat_t eb;
        res_t  er;
        @(negedge clk);
        cyc++;
        if (ofm_valid) begin
            if (rq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ofm_extra: got data %0h id %0d, expected no result (cycle %0d)",
                         ofm_data, ofm_id, cyc);
            end else begin
                er = rq.pop_front();
                check("ofm", 64'({ofm_id, ofm_last, ofm_data}), 64'({er.id, er.last, er.d}));
                last_ofm_cyc = cyc;
                if (ofm_last) mon_last = 1'b1;
            end
        end
        if (eng_in_valid) begin
            if (bq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL beat_extra: got ifm %0h, expected no beat (cycle %0d)", eng_ifm, cyc);
            end else begin
                eb = bq.pop_front();
                check("beat", 64'({eng_weight_valid, eng_weight, eng_ifm}),
                      64'({eb.wv, eb.w, eb.ifm}));
            end
        end else if (eng_weight_valid) begin
            tests++;
            fails++;
            $display("FAIL weight_no_in: got weight_valid 1 expected 0 (cycle %0d)", cyc);
        end
        if (|gnt) begin
            gnt_cnt++;
            last_gnt = gnt;
            gnt_cyc = cyc;
        end
        if (|job_done) begin
            mon_done = mon_done | job_done;
            end_cyc = cyc;
        end
        if (|job_err) begin
            mon_err = mon_err | job_err;
            end_cyc = cyc;
        end
    endtask

    task automatic drive_beat(input int k, input bit sel);
        logic [DATA_W-1:0] ifm, w;
        ifm = 16'(k) | (sel ? 16'h1000 : 16'h0000);
        w   = (k < 9) ? 16'(k + 1) : 16'hA5A5;
        s_valid = sel ? 2'b10 : 2'b01;
        if (sel) begin
            s1_ifm = ifm; s1_w = w; s0_ifm = ~ifm; s0_w = ~w;
        end else begin
            s0_ifm = ifm; s0_w = w; s1_ifm = ~ifm; s1_w = ~w;
        end
        bq.push_back('{ifm: ifm, wv: (k < 9), w: ((k < 9) ? w : 16'h0)});
    endtask

    task automatic run_job(input vec_t v);
        int  t0, pe, k, r;
        bit  fin;
        res_t er;
        jid++;
        mon_done = 2'b00;
        mon_err  = 2'b00;
        mon_last = 1'b0;
        gnt_cnt  = 0;
        pe = end_cyc;
        req = v.req;
        t0 = cyc;
        while (gnt_cnt == 0 && (cyc - t0) < 40) tick();
        if (gnt_cnt == 0) begin
            tests++;
            fails++;
            $display("FAIL gnt_wait: got no grant expected grant to %0d (job %0d)", v.win, jid);
            req = 2'b00;
            return;
        end
        check("winner", 64'(last_gnt), v.win ? 64'h2 : 64'h1);
        if (v.gap > 0) check("grant_gap", 64'(gnt_cyc - pe), 64'(v.gap));
        if (!v.hold) req = 2'b00;
        tick();
        fin = 1'b0;
        for (k = 0; k < 200; k++) begin
            s_valid = 2'b00;
            eng_out_valid = 1'b0;
            if (k < v.nsend) drive_beat(k, v.win);
            r = k - v.rstart;
            if (v.nres > 0 && r >= 0 && r < v.nres) begin
                eng_out_valid = 1'b1;
                eng_ofm = {4'hC, 16'(jid), 16'(r)};
                if (r < v.fwd) begin
                    er.d = eng_ofm;
                    er.id = v.win;
                    er.last = v.last && (r == v.fwd - 1);
                    rq.push_back(er);
                end
            end
            tick();
            if ((mon_done | mon_err) != 2'b00 && k >= v.rstart + v.nres - 1) begin
                fin = 1'b1;
                break;
            end
        end
        s_valid = 2'b00;
        eng_out_valid = 1'b0;
        if (!fin) begin
            tests++;
            fails++;
            $display("FAIL job_end: got no done/err within 200 cycles expected end (job %0d)", jid);
        end
        check("gnt_once", 64'(gnt_cnt), 64'h1);
        check("job_done", 64'(mon_done), v.done ? (v.win ? 64'h2 : 64'h1) : 64'h0);
        check("job_err", 64'(mon_err), v.err ? (v.win ? 64'h2 : 64'h1) : 64'h0);
        check("ofm_last_seen", 64'(mon_last), 64'(v.last));
        check("ofm_drained", 64'(rq.size()), 64'h0);
        if (v.err && v.nsend == 49) check("timeout_gap", 64'(end_cyc - last_ofm_cyc), 64'd16);
        if (v.err && v.nsend < 49) check("abort_in_valid", 64'(eng_in_valid), 64'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int tA;
        rst_n = 1'b0;
        req = 2'b00;
        s_valid = 2'b00;
        s0_ifm = '0; s0_w = '0; s1_ifm = '0; s1_w = '0;
        eng_out_valid = 1'b0;
        eng_ofm = '0;
        #3;
        check_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_zero("post_reset");

        vecs[0] = '{req:2'b01, hold:0, win:0, nsend:49, nres:25, rstart:30, fwd:25, done:1, err:0, last:1, gap:0};
        vecs[1] = '{req:2'b11, hold:1, win:1, nsend:49, nres:25, rstart:49, fwd:25, done:1, err:0, last:1, gap:5};
        vecs[2] = '{req:2'b11, hold:1, win:0, nsend:49, nres:25, rstart:49, fwd:25, done:1, err:0, last:1, gap:5};
        vecs[3] = '{req:2'b11, hold:1, win:1, nsend:49, nres:27, rstart:49, fwd:25, done:1, err:0, last:1, gap:5};
        vecs[4] = '{req:2'b10, hold:0, win:1, nsend:49, nres:10, rstart:49, fwd:10, done:0, err:1, last:0, gap:7};
        vecs[5] = '{req:2'b01, hold:0, win:0, nsend:20, nres:0,  rstart:0,  fwd:0,  done:0, err:1, last:0, gap:5};

        for (int i = 0; i < 6; i++) run_job(vecs[i]);

        // Results arriving during FLUSH are dropped and restart the quiet count.
        tA = cyc;
        gnt_cnt = 0;
        req = 2'b01;
        eng_out_valid = 1'b1;
        eng_ofm = 36'hF_0000_0001;
        tick();
        eng_ofm = 36'hF_0000_0002;
        tick();
        eng_out_valid = 1'b0;
        while (gnt_cnt == 0 && (cyc - tA) < 30) tick();
        check("flush_grant_gap", 64'(gnt_cyc - tA), 64'd7);
        check("flush_winner", 64'(last_gnt), 64'h1);
        req = 2'b00;

        // Reset asserted mid-stream at beat 30.
        tick();
        for (int k = 0; k < 30; k++) begin
            drive_beat(k, 1'b0);
            tick();
        end
        drive_beat(30, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        bq.delete();
        rq.delete();
        s_valid = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_job('{req:2'b10, hold:0, win:1, nsend:49, nres:25, rstart:49, fwd:25, done:1, err:0, last:1, gap:0});
        run_job('{req:2'b11, hold:0, win:0, nsend:49, nres:25, rstart:30, fwd:25, done:1, err:0, last:1, gap:0});
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
